bcd2bin32: RTL and testbench

- Sequential 10-digit BCD to 32-bit binary converter; the inverse of the team's multi-cycle binary-to-BCD converter.
- Uses reverse double-dabble: one right-shift plus per-digit correction per clock, 32 iterations.
- Sits between decimal-entry or display-side logic (keypad, UART decimal parser) and binary datapaths.
- Shares the en/busy/fin handshake with the binary-to-BCD converter so the two are interchangeable to a controller.

---
 rtl/bcd2bin32.sv | 192 +++++++++++++++++++
 tb/tb_bcd2bin32.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd2bin32.sv
// -----------------------------------------------------------------------------
// bcd2bin32 -- sequential 10-digit BCD to 32-bit binary converter
//
// Reverse double-dabble: each BUSY cycle shifts the 72-bit pair {bcd, bin}
// right by one bit, then corrects every BCD digit that reads >= 8 by
// subtracting 3. After 32 such steps, bin holds the value modulo 2^32. The
// BCD register then holds whatever did not fit in 32 bits.
//
// The en/busy/fin handshake matches the binary-to-BCD converter, so a
// controller can drive either block in the same way.
//
// Ports
//   CLK          in   1   clock, rising edge
//   RST          in   1   asynchronous reset, active low
//   en           in   1   start request, sampled only in IDLE
//   bcd0..bcd9   in   4   BCD digits, bcd0 least significant; sampled on the
//                         accepting edge only
//   bin          out  32  binary result; valid with fin, held until next start
//   busy         out  1   high while converting and during the fin cycle
//   fin          out  1   one-cycle pulse, result valid
//   err          out  1   result invalid; valid with fin
//
// Optional feature (compile-time macro BCD2BIN_CHECK_EN)
//   Defined   : err flags an input digit > 9, or a value above 4294967295
//               (the BCD register is non-zero after the last shift).
//   Undefined : err is tied low and no checking logic is built.
// -----------------------------------------------------------------------------
module bcd2bin32 (
    input  logic        CLK,
    input  logic        RST,
    input  logic        en,
    input  logic [3:0]  bcd0,
    input  logic [3:0]  bcd1,
    input  logic [3:0]  bcd2,
    input  logic [3:0]  bcd3,
    input  logic [3:0]  bcd4,
    input  logic [3:0]  bcd5,
    input  logic [3:0]  bcd6,
    input  logic [3:0]  bcd7,
    input  logic [3:0]  bcd8,
    input  logic [3:0]  bcd9,
    output logic [31:0] bin,
    output logic        busy,
    output logic        fin,
    output logic        err
);

    localparam int DIGITS   = 10;
    localparam int BCD_W    = 4 * DIGITS;
    localparam int BIN_W    = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        BUSY    = 2'b01,
        FIN     = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    state_t             state_reg;
    logic [4:0]         bitcount_reg;
    logic [BCD_W-1:0]   bcd_reg;
    logic [BIN_W-1:0]   bin_reg;
    logic               busy_reg;
    logic               fin_reg;

    logic [BCD_W-1:0]   bcd_in;
    logic [BCD_W-1:0]   bcd_shifted;
    logic [BCD_W-1:0]   bcd_next;
    logic [BIN_W-1:0]   bin_next;
    logic               accept;
    logic               last_shift;

    assign bcd_in = {bcd9, bcd8, bcd7, bcd6, bcd5, bcd4, bcd3, bcd2, bcd1, bcd0};

    assign accept     = (state_reg == IDLE) && en;
    assign last_shift = (state_reg == BUSY) && (bitcount_reg == 5'd31);

    // One right shift of the 72-bit pair: the BCD LSB crosses into bin[31].
    assign bcd_shifted = {1'b0, bcd_reg[BCD_W-1:1]};
    assign bin_next    = {bcd_reg[0], bin_reg[BIN_W-1:1]};

    // Halving a BCD number moves a '1' from a digit's LSB into the next lower
    // digit's MSB, where it is worth 8 instead of 5. Subtracting 3 from any
    // digit that reads 8 or more restores the decimal weight.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit_fix
            logic [3:0] digit;
            assign digit = bcd_shifted[4*gi +: 4];
            assign bcd_next[4*gi +: 4] = digit[3] ? (digit - 4'd3) : digit;
        end
    endgenerate

    // Control, shift datapath and handshake outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg    <= IDLE;
            bitcount_reg <= 5'd0;
            bcd_reg      <= '0;
            bin_reg      <= '0;
            busy_reg     <= 1'b0;
            fin_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    bitcount_reg <= 5'd0;
                    fin_reg      <= 1'b0;
                    if (en) begin
                        bcd_reg   <= bcd_in;
                        bin_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= BUSY;
                    end else begin
                        busy_reg  <= 1'b0;
                    end
                end

                BUSY: begin
                    bcd_reg  <= bcd_next;
                    bin_reg  <= bin_next;
                    busy_reg <= 1'b1;
                    if (bitcount_reg == 5'd31) begin
                        bitcount_reg <= 5'd0;
                        fin_reg      <= 1'b1;
                        state_reg    <= FIN;
                    end else begin
                        bitcount_reg <= bitcount_reg + 5'd1;
                        fin_reg      <= 1'b0;
                    end
                end

                FIN: begin
                    // bin and bcd_reg hold; only the handshake moves on.
                    bitcount_reg <= 5'd0;
                    fin_reg      <= 1'b0;
                    busy_reg     <= 1'b0;
                    state_reg    <= IDLE;
                end

                default: begin
                    // Unused encoding: recover to IDLE without a result.
                    bitcount_reg <= 5'd0;
                    fin_reg      <= 1'b0;
                    busy_reg     <= 1'b0;
                    state_reg    <= IDLE;
                end
            endcase
        end
    end

    assign bin  = bin_reg;
    assign busy = busy_reg;
    assign fin  = fin_reg;

`ifdef BCD2BIN_CHECK_EN
    logic             err_pend_reg;
    logic             err_reg;
    logic [DIGITS-1:0] digit_gt9;
    logic             digit_bad;
    logic             residual_nz;

    // A digit exceeds 9 when its MSB is set together with bit 2 or bit 1.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit_chk
            assign digit_gt9[gi] = bcd_in[4*gi+3] & (bcd_in[4*gi+2] | bcd_in[4*gi+1]);
        end
    endgenerate

    assign digit_bad = |digit_gt9;

    // bcd_next on the final shift is the residual left after 32 halvings.
    // Anything non-zero there means the input did not fit in 32 bits.
    assign residual_nz = |bcd_next;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            err_pend_reg <= 1'b0;
            err_reg      <= 1'b0;
        end else if (accept) begin
            err_pend_reg <= digit_bad;
            err_reg      <= 1'b0;
        end else if (last_shift) begin
            err_pend_reg <= err_pend_reg | residual_nz;
            err_reg      <= err_pend_reg | residual_nz;
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd2bin32.sv
module tb_bcd2bin32;

    logic        CLK;
    logic        RST;
    logic        en;
    logic [39:0] dig_bus;
    logic [31:0] bin;
    logic        busy;
    logic        fin;
    logic        err;

    int checks;
    int errors;

    bcd2bin32 dut (
        .CLK  (CLK),
        .RST  (RST),
        .en   (en),
        .bcd0 (dig_bus[3:0]),
        .bcd1 (dig_bus[7:4]),
        .bcd2 (dig_bus[11:8]),
        .bcd3 (dig_bus[15:12]),
        .bcd4 (dig_bus[19:16]),
        .bcd5 (dig_bus[23:20]),
        .bcd6 (dig_bus[27:24]),
        .bcd7 (dig_bus[31:28]),
        .bcd8 (dig_bus[35:32]),
        .bcd9 (dig_bus[39:36]),
        .bin  (bin),
        .busy (busy),
        .fin  (fin),
        .err  (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: decimal value of the digit string using plain arithmetic.
    function automatic longint unsigned bcd_value(input logic [39:0] d);
        longint unsigned v;
        v = 0;
        for (int i = 9; i >= 0; i--) v = v * 10 + longint'(d[4*i +: 4]);
        return v;
    endfunction

    function automatic bit has_bad_digit(input logic [39:0] d);
        bit b;
        b = 0;
        for (int i = 0; i < 10; i++) if (d[4*i +: 4] > 4'd9) b = 1;
        return b;
    endfunction

    // Start a conversion (caller sits 1 time unit after a rising edge with the
    // DUT idle), wait for fin, compare against the reference, and return one
    // time unit after the edge that ends the fin cycle.
    task automatic convert(input logic [39:0] dig, input bit noisy, input string tag);
        int              n;
        bit              seen;
        longint unsigned v;
        bit              bad;
        logic [31:0]     exp_bin;
        logic            exp_err;
        logic [31:0]     got_bin;

        v   = bcd_value(dig);
        bad = has_bad_digit(dig);
        exp_bin = v[31:0];
`ifdef BCD2BIN_CHECK_EN
        exp_err = bad || (v > 64'h00000000FFFFFFFF);
`else
        exp_err = 1'b0;
`endif
        dig_bus = dig;
        en      = 1'b1;
        @(posedge CLK); #1;
        en      = 1'b0;
        dig_bus = 40'({$urandom(), $urandom()});
        check({tag, ".busy_rise"}, 64'(busy), 64'(1));
        n    = 0;
        seen = 0;
        while (!seen && n < 40) begin
            if (noisy && n == 10) begin
                en      = 1'b1;
                dig_bus = 40'({$urandom(), $urandom()});
            end
            if (noisy && n == 11) en = 1'b0;
            @(posedge CLK); #1;
            n++;
            if (fin) seen = 1;
        end
        en = 1'b0;
        check({tag, ".latency"}, 64'(n), 64'(32));
        got_bin = bin;
        if (!bad) check({tag, ".bin"}, 64'(bin), 64'(exp_bin));
        check({tag, ".err"}, 64'(err), 64'(exp_err));
        $display("conv %s digits=%h bin=%h err=%b edges_to_fin=%0d", tag, dig, bin, err, n);
        @(posedge CLK); #1;
        check({tag, ".fin_one_cycle"}, 64'(fin), 64'(0));
        check({tag, ".busy_fall"}, 64'(busy), 64'(0));
        check({tag, ".bin_hold"}, 64'(bin), 64'(got_bin));
    endtask

    logic [39:0] rd;
    int          nd;
    int          fins;
    int          fin_at[3];
    int          k;

    initial begin
        checks  = 0;
        errors  = 0;
        RST     = 1'b0;
        en      = 1'b0;
        dig_bus = '0;
        #1;
        check("reset.bin",  64'(bin),  64'(0));
        check("reset.busy", 64'(busy), 64'(0));
        check("reset.fin",  64'(fin),  64'(0));
        check("reset.err",  64'(err),  64'(0));
        repeat (3) @(posedge CLK);
        @(negedge CLK) RST = 1'b1;
        @(posedge CLK); #1;

        // Directed cases
        convert(40'h0000000000, 0, "zero");
        check("zero.bin_const", 64'(bin), 64'(32'h00000000));

        convert(40'h0012345678, 0, "d12345678");
        repeat (10) @(posedge CLK);
        #1;
        check("d12345678.hold10", 64'(bin), 64'(32'h00BC614E));

        convert(40'h4294967295, 0, "max");
        check("max.bin_const", 64'(bin), 64'(32'hFFFFFFFF));
        convert(40'h4294967296, 0, "max_plus1");
        convert(40'h000000A000, 0, "bad_digit");
        convert(40'h9999999999, 0, "all9");
        convert(40'h0000000123, 1, "noisy_en");

        // en held high: back-to-back conversions every 34 cycles
        dig_bus = 40'h0000000099;
        en      = 1'b1;
        fins    = 0;
        k       = 0;
        while (fins < 3 && k < 120) begin
            @(posedge CLK); #1;
            k++;
            if (fin) begin
                fin_at[fins] = k;
                fins++;
                check("hold_en.bin", 64'(bin), 64'(32'h00000063));
                $display("hold_en fin #%0d at edge %0d bin=%h", fins, k, bin);
            end
        end
        en = 1'b0;
        check("hold_en.count", 64'(fins), 64'(3));
        if (fins == 3) begin
            check("hold_en.first", 64'(fin_at[0]), 64'(33));
            check("hold_en.period1", 64'(fin_at[1] - fin_at[0]), 64'(34));
            check("hold_en.period2", 64'(fin_at[2] - fin_at[1]), 64'(34));
        end
        @(posedge CLK); #1;
        check("hold_en.idle", 64'(busy), 64'(0));

        // Reset in mid-conversion
        dig_bus = 40'h4294967295;
        en      = 1'b1;
        @(posedge CLK); #1;
        en = 1'b0;
        repeat (15) @(posedge CLK);
        #2;
        RST = 1'b0;
        #1;
        check("midrst.busy", 64'(busy), 64'(0));
        check("midrst.fin",  64'(fin),  64'(0));
        check("midrst.err",  64'(err),  64'(0));
        check("midrst.bin",  64'(bin),  64'(0));
        @(negedge CLK);
        @(negedge CLK) RST = 1'b1;
        fins = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK); #1;
            if (fin) fins++;
        end
        check("midrst.no_fin", 64'(fins), 64'(0));
        $display("midrst aborted, fins after release=%0d", fins);
        convert(40'h0000000007, 0, "after_rst");
        check("after_rst.bin_const", 64'(bin), 64'(32'h00000007));

        // Randomised conversions against the reference model
        for (int t = 0; t < 24; t++) begin
            rd = '0;
            nd = int'($urandom_range(10, 1));
            for (int i = 0; i < nd; i++) rd[4*i +: 4] = 4'($urandom_range(9, 0));
            if ($urandom_range(7, 0) == 0)
                rd[4*int'($urandom_range(nd - 1, 0)) +: 4] = 4'($urandom_range(15, 10));
            convert(rd, (t % 3) == 0, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
